// File: rtl/dmem_responder.sv
// Word-addressed 16-bit data memory responder with fixed latency and one outstanding request.
// Optional address bounds checking is enabled with `define DMEM_RESP_BOUNDS_CHECK_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                lat_wr;
    logic                lat_oor;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                oor_c;
    logic                accept_c;
    logic                wr_en_c;
    logic [DATA_W-1:0]   rd_data_c;

`ifdef DMEM_RESP_BOUNDS_CHECK_EN
    assign oor_c = |req_addr[15:ADDR_W];
`else
    // Upper address bits are ignored; the address wraps modulo the array depth.
    logic unused_c;
    assign unused_c = ^req_addr[15:ADDR_W];
    assign oor_c    = 1'b0;
`endif

    assign accept_c  = (state == IDLE) && req_valid;
    // Gating with rst_n keeps a store from landing while reset holds the FSM in IDLE.
    assign wr_en_c   = rst_n && accept_c && req_wr && !oor_c;
    assign rd_data_c = mem[lat_addr];

    // Storage array: not reset, written at the acceptance edge of an in-range store.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[req_addr[ADDR_W-1:0]] <= req_wdata;
        end
    end

    // Control FSM; req_ready/rsp_valid are registered alongside the state so they decode it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_wr    <= 1'b0;
            lat_oor   <= 1'b0;
            lat_addr  <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_wr    <= req_wr;
                        lat_oor   <= oor_c;
                        lat_addr  <= req_addr[ADDR_W-1:0];
                        cnt       <= CNT_W'(LATENCY - 1);
                        state     <= BUSY;
                        req_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (lat_wr || lat_oor) ? '0 : rd_data_c;
                        rsp_err   <= lat_oor;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=4 main instance, LATENCY=1 boundary instance).
module tb_dmem_responder;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;

    logic        lreq_valid = 1'b0, lreq_wr = 1'b0, lrsp_ready = 1'b0;
    logic [15:0] lreq_addr = '0, lreq_wdata = '0;
    logic        lreq_ready, lrsp_valid, lrsp_err;
    logic [15:0] lrsp_rdata;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(lreq_valid), .req_ready(lreq_ready), .req_wr(lreq_wr),
        .req_addr(lreq_addr), .req_wdata(lreq_wdata),
        .rsp_valid(lrsp_valid), .rsp_ready(lrsp_ready),
        .rsp_rdata(lrsp_rdata), .rsp_err(lrsp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request on the main instance and consumes its response; returns observed values.
    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata, output logic err, output int lat);
        int w;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
        w = 0;
        while (!req_ready && w < 50) begin step(); w++; end
        step();
        req_valid = 1'b0;
        lat = 0;
        do begin step(); lat++; end while (!rsp_valid && lat < 50);
        rdata = rsp_rdata; err = rsp_err;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        vecs++; if (rsp_rdata !== 16'h0) begin errs++; $display("FAIL rst_rsp_rdata: got %h want 0000", rsp_rdata); end
        vecs++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vecs++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
                errs++;
                $display("FAIL idle_cycle%0d: got rdy=%b vld=%b data=%h err=%b want 1 0 0000 0",
                         i, req_ready, rsp_valid, rsp_rdata, rsp_err);
            end
        end
    endtask

    task automatic test_store_load();
        logic [15:0] d; logic e; int lat;
        do_req(1'b1, 16'h0005, 16'hBEEF, d, e, lat);
        vecs++; if (lat !== 4) begin errs++; $display("FAIL store_latency: got %0d want 4", lat); end
        vecs++; if (d !== 16'h0000) begin errs++; $display("FAIL store_ack_data: got %h want 0000", d); end
        vecs++; if (e !== 1'b0) begin errs++; $display("FAIL store_err: got %b want 0", e); end
        do_req(1'b0, 16'h0005, 16'h0000, d, e, lat);
        vecs++; if (lat !== 4) begin errs++; $display("FAIL load_latency: got %0d want 4", lat); end
        vecs++; if (d !== 16'hBEEF) begin errs++; $display("FAIL load_data: got %h want beef", d); end
    endtask

    task automatic test_backpressure();
        logic [15:0] d; logic e; int lat;
        do_req(1'b1, 16'h0020, 16'hA5A5, d, e, lat);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0020;
        step();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin step(); lat++; end
        vecs++; if (lat !== 4) begin errs++; $display("FAIL bp_latency: got %0d want 4", lat); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'hDEAD; end
            if (i == 4) req_valid = 1'b0;
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5A5 || req_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold%0d: got vld=%b data=%h rdy=%b want 1 a5a5 0", i, rsp_valid, rsp_rdata, req_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errs++;
                $display("FAIL bp_after%0d: got vld=%b rdy=%b want 0 1", i, rsp_valid, req_ready);
            end
            step();
        end
        do_req(1'b0, 16'h0020, 16'h0000, d, e, lat);
        vecs++; if (d !== 16'hA5A5) begin errs++; $display("FAIL bp_no_accept: got %h want a5a5", d); end
    endtask

    task automatic test_back_to_back();
        logic        wr_v [6];
        logic [15:0] ad_v [6];
        logic [15:0] wd_v [6];
        logic [15:0] model [int];
        logic [15:0] exp_q [$];
        int          acc_t [$];
        int          idx, nrsp;
        logic        acc;
        wr_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ad_v = '{16'h0040, 16'h0040, 16'h0041, 16'h0041, 16'h0040, 16'h0040};
        wd_v = '{16'h1111, 16'h0000, 16'h2222, 16'h0000, 16'h3333, 16'h0000};
        idx = 0; nrsp = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_wr = wr_v[0]; req_addr = ad_v[0]; req_wdata = wd_v[0];
        for (int t = 0; t < 200 && nrsp < 6; t++) begin
            acc = req_ready && req_valid;
            step();
            if (acc) begin
                acc_t.push_back(t);
                exp_q.push_back(wr_v[idx] ? 16'h0000 : model[int'(ad_v[idx])]);
                if (wr_v[idx]) model[int'(ad_v[idx])] = wd_v[idx];
                idx++;
                if (idx < 6) begin req_wr = wr_v[idx]; req_addr = ad_v[idx]; req_wdata = wd_v[idx]; end
                else req_valid = 1'b0;
            end
            if (rsp_valid) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL b2b_extra_rsp: got data=%h want no response", rsp_rdata);
                end else if (rsp_rdata !== exp_q[0]) begin
                    errs++; $display("FAIL b2b_rsp%0d: got %h want %h", nrsp, rsp_rdata, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                nrsp++;
            end
        end
        step();
        req_valid = 1'b0; rsp_ready = 1'b0;
        vecs++; if (nrsp !== 6) begin errs++; $display("FAIL b2b_count: got %0d want 6", nrsp); end
        for (int i = 1; i < acc_t.size(); i++) begin
            vecs++;
            if (acc_t[i] - acc_t[i-1] !== int'(LATENCY + 2)) begin
                errs++; $display("FAIL b2b_interval%0d: got %0d want %0d", i, acc_t[i] - acc_t[i-1], LATENCY + 2);
            end
        end
    endtask

    task automatic test_bounds();
        logic [15:0] d; logic e; int lat;
        do_req(1'b1, 16'h0000, 16'h0F0F, d, e, lat);
        do_req(1'b1, 16'h0400, 16'h1234, d, e, lat);
`ifdef DMEM_RESP_BOUNDS_CHECK_EN
        vecs++; if (e !== 1'b1) begin errs++; $display("FAIL oor_store_err: got %b want 1", e); end
        do_req(1'b0, 16'h0000, 16'h0000, d, e, lat);
        vecs++; if (d !== 16'h0F0F) begin errs++; $display("FAIL oor_store_dropped: got %h want 0f0f", d); end
        vecs++; if (e !== 1'b0) begin errs++; $display("FAIL inrange_err: got %b want 0", e); end
        do_req(1'b0, 16'h0400, 16'h0000, d, e, lat);
        vecs++; if (d !== 16'h0000 || e !== 1'b1) begin errs++; $display("FAIL oor_load: got data=%h err=%b want 0000 1", d, e); end
`else
        vecs++; if (e !== 1'b0) begin errs++; $display("FAIL wrap_store_err: got %b want 0", e); end
        do_req(1'b0, 16'h0000, 16'h0000, d, e, lat);
        vecs++; if (d !== 16'h1234) begin errs++; $display("FAIL wrap_load: got %h want 1234", d); end
        vecs++; if (e !== 1'b0) begin errs++; $display("FAIL wrap_load_err: got %b want 0", e); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [15:0] d; logic e; int lat;
        int rises;
        do_req(1'b1, 16'h0007, 16'h5A5A, d, e, lat);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0008; req_wdata = 16'h6B6B;
        step();
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0007;
        step();
        req_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        vecs++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_state: got vld=%b rdy=%b want 0 1", rsp_valid, req_ready); end
        step(); step();
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 8; i++) begin step(); if (rsp_valid) rises++; end
        vecs++; if (rises !== 0) begin errs++; $display("FAIL rst_mid_no_rsp: got %0d cycles valid want 0", rises); end
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
        do_req(1'b0, 16'h0007, 16'h0000, d, e, lat);
        vecs++; if (d !== 16'h5A5A) begin errs++; $display("FAIL rst_mid_reload: got %h want 5a5a", d); end
        do_req(1'b0, 16'h0008, 16'h0000, d, e, lat);
        vecs++; if (d !== 16'h6B6B) begin errs++; $display("FAIL rst_mid_store_kept: got %h want 6b6b", d); end
    endtask

    task automatic test_latency_one();
        lreq_valid = 1'b1; lreq_wr = 1'b1; lreq_addr = 16'h0003; lreq_wdata = 16'h0077; lrsp_ready = 1'b0;
        step();
        lreq_valid = 1'b0;
        vecs++; if (lrsp_valid !== 1'b0 || lreq_ready !== 1'b0) begin errs++; $display("FAIL l1_busy: got vld=%b rdy=%b want 0 0", lrsp_valid, lreq_ready); end
        step();
        vecs++; if (lrsp_valid !== 1'b1 || lrsp_rdata !== 16'h0) begin errs++; $display("FAIL l1_store_rsp: got vld=%b data=%h want 1 0000", lrsp_valid, lrsp_rdata); end
        lrsp_ready = 1'b1; step(); lrsp_ready = 1'b0;
        lreq_valid = 1'b1; lreq_wr = 1'b0;
        step();
        lreq_valid = 1'b0;
        vecs++; if (lrsp_valid !== 1'b0) begin errs++; $display("FAIL l1_load_busy: got vld=%b want 0", lrsp_valid); end
        step();
        vecs++; if (lrsp_valid !== 1'b1 || lrsp_rdata !== 16'h0077) begin errs++; $display("FAIL l1_load_rsp: got vld=%b data=%h want 1 0077", lrsp_valid, lrsp_rdata); end
        lrsp_ready = 1'b1; step(); lrsp_ready = 1'b0;
        vecs++; if (lreq_ready !== 1'b1 || lrsp_valid !== 1'b0) begin errs++; $display("FAIL l1_idle: got rdy=%b vld=%b want 1 0", lreq_ready, lrsp_valid); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_backpressure();
        test_back_to_back();
        test_bounds();
        test_latency_one();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Single-port, word-addressed 16-bit data memory responder that services load/store requests from the pipelined CPU's MEM stage over a valid/ready request channel and returns results over a valid/ready response channel. It models a fixed multi-cycle memory latency, allows one outstanding request, and is the target side of the CPU's data-memory interface. The CPU stalls MEM while `req_ready` or `rsp_valid` is low.

## Interface
- `ADDR_W`, 10: word-address width; the array depth is 2^ADDR_W 16-bit words.
- `LATENCY`, 4: cycles from request acceptance to `rsp_valid`; legal range 1..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  CPU presents a request.
- `req_ready`  out  1  responder can accept a request; high only in IDLE.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_addr`  in  16  word address.
- `req_wdata`  in  16  store data.
- `rsp_valid`  out  1  response available; high only in RESP.
- `rsp_ready`  in  1  CPU consumes the response.
- `rsp_rdata`  out  16  load data; 16'h0000 for stores.
- `rsp_err`  out  1  address out of range (see Configuration).

## Operation
- The FSM has three states: IDLE, BUSY and RESP. A 4-bit down-counter `cnt` tracks the latency.
- **IDLE:** `req_ready`=1. On `req_valid` at an edge, the request is accepted:
  - `req_wr`, `req_addr` and `req_wdata` are latched.
  - `cnt` ← LATENCY-1.
  - The state moves to BUSY.
  - A store writes the array at this same edge, subject to the range rule.
- **BUSY:** `req_ready`=0 and `rsp_valid`=0.
  - If `cnt`==0 at an edge, the state moves to RESP and `rsp_rdata`/`rsp_err` are registered.
  - Otherwise `cnt` decrements.
  - A load captures array data at the latched address on that transition edge.
- **RESP:** `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable until the handshake.
  - On `rsp_ready` at an edge, the state moves to IDLE and `rsp_rdata` and `rsp_err` clear to 0.
  - Without `rsp_ready`, the state stays in RESP indefinitely.
- **Stores:** every store also produces a response, with `rsp_rdata`=16'h0000 acting as the write acknowledgement.
- **Read-after-write:** a load issued after the store's response returns the stored value.
- **Inputs outside IDLE:** `req_*` are ignored outside IDLE. A request held during BUSY/RESP is not lost; it is accepted on the first edge back in IDLE.
- **Addressing:** the in-range address is `req_addr[ADDR_W-1:0]`. Out of range means any of `req_addr[15:ADDR_W]` is nonzero.
- **Array contents:** not reset; undefined until written.

## Timing
- Reset values while `rst_n`=0: state IDLE, `cnt`=0, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Request accepted at edge N → `rsp_valid` rises after edge N+LATENCY.
- With `rsp_ready` held high, the response is consumed at edge N+LATENCY+1 and `req_ready` is high again after that edge.
- The next acceptance is no earlier than edge N+LATENCY+2, so peak throughput is one request per LATENCY+2 cycles.
- LATENCY=1 boundary: BUSY lasts exactly one cycle.
- Reset asserted mid-transaction (BUSY or RESP) returns the FSM to IDLE immediately and drops the response.
  - A store accepted before reset stays committed.
  - A pending load is discarded.
- `req_ready` and `rsp_valid` are pure decodes of the state register; neither depends combinationally on `req_valid` or `rsp_ready`.

## Configuration
- `DMEM_RESP_BOUNDS_CHECK_EN` defined:
  - Out-of-range stores are dropped, so the array is unchanged.
  - Out-of-range loads return `rsp_rdata`=16'h0000.
  - Both set `rsp_err`=1 in RESP.
- Not defined:
  - The upper address bits are ignored and the address wraps modulo 2^ADDR_W.
  - `rsp_err` is tied to 0.

## Test plan
- Reset, then idle: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0 on every cycle.
- Store addr 16'h0005, data 16'hBEEF at edge N (LATENCY=4) → `rsp_valid` high after edge N+4 with `rsp_rdata`=0. Then load 16'h0005 → `rsp_rdata`=16'hBEEF exactly 4 edges after acceptance.
- Load response with `rsp_ready` held low for 10 cycles → `rsp_valid`=1 with `rsp_rdata` stable throughout; `req_ready`=0; a `req_valid` pulse during the wait is not accepted.
- `req_valid` held high continuously with alternating stores and loads → one acceptance every LATENCY+2 cycles; every response's data matches a reference model.
- Store 16'h1234 to 16'h0400 (ADDR_W=10):
  - With `DMEM_RESP_BOUNDS_CHECK_EN`: `rsp_err`=1; a load of 16'h0000 is unaffected.
  - Without it: `rsp_err`=0; a load of 16'h0000 returns 16'h1234.
- Assert `rst_n` low in BUSY during a load of a written address → `rsp_valid` never rises for that load; after release `req_ready`=1 and a reload returns the prior data.
